full_handshake_tx_arbiter: RTL and testbench
============================================

// Module: full_handshake_tx_arbiter
// PURPOSE
//   Shares one full-handshake CDC transmit channel among NUM_REQ requesters in the clk_t domain.
//   Round-robin arbitration picks one requester, captures its word and drives a 4-phase req/ack
//   handshake toward the CDC channel. ch_ack arrives already synchronised into clk_t.
//   Only one transfer is in flight at a time. The next grant is issued only after ack is low again.
// PARAMETERS
//   NUM_REQ      4    number of requesters (2..8)
//   DATA_W       32   data width per requester and on the channel
//   ID_W         2    width of the granted index; must equal clog2(NUM_REQ)
//   TIMEOUT_CYC  64   cycles to wait for ack high before abort (used only with the macro)
// PORTS
//   clk_t        in   1                transmit-domain clock
//   rst_n_t      in   1                asynchronous, active-low reset
//   req_val      in   NUM_REQ          per-requester valid; data must stay stable while high
//   req_data     in   NUM_REQ*DATA_W   requester i occupies bits [i*DATA_W +: DATA_W]
//   req_rdy      out  NUM_REQ          one-hot accept; a transfer happens when req_val[i]&req_rdy[i]
//   ch_req       out  1                4-phase request to the CDC channel (registered)
//   ch_data      out  DATA_W           captured word; stable while ch_req=1 (registered)
//   ch_ack       in   1                channel ack, already synchronised to clk_t
//   busy         out  1                high whenever state != IDLE
//   xfer_done    out  1                1-cycle pulse when a transfer fully completes (ack returned low)
//   xfer_id      out  ID_W             index of the granted requester; held until the next grant
//   timeout_err  out  1                1-cycle pulse on abort (tied 0 without the macro)
// BEHAVIOUR
//   Reset values (async): state=IDLE, all outputs 0, rr_ptr=NUM_REQ-1 (so requester 0 wins first).
//   FSM states: IDLE -> REQ_HI -> WAIT_LO -> IDLE.
//   IDLE
//     - winner = first i with req_val[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
//     - req_rdy = onehot(winner), combinational; all zero when no req_val or state != IDLE.
//     - On an accepting edge: ch_data<=word, ch_req<=1, xfer_id<=winner, rr_ptr<=winner, go REQ_HI.
//   REQ_HI
//     - Hold ch_req=1 and ch_data stable.
//     - ch_ack=1 sampled: ch_req<=0, go WAIT_LO.
//   WAIT_LO
//     - ch_ack=0 sampled: xfer_done<=1 for one cycle, go IDLE.
//     - The earliest possible next grant is on the cycle in which xfer_done is high.
//   Latency
//     - Accept edge to ch_req high: 0 cycles (same edge).
//     - ack rise to ch_req fall: 1 edge.
//     - ack fall to xfer_done: 1 edge.
//   Boundary cases
//     - ch_ack already high in IDLE: ignored; REQ_HI still waits for ack=1, and WAIT_LO absorbs it.
//     - ch_ack high on the accepting edge: no effect on that edge.
//     - req_val dropped by a non-granted requester: no effect.
//     - req_val dropped by the granted requester after acceptance: no effect (data already captured).
//     - Requester that keeps req_val high: wins again only after all others with val=1 are served.
//     - Wrap-around: rr_ptr=NUM_REQ-1 scans 0 next.
//     - Reset mid-transfer: ch_req drops asynchronously; the channel must tolerate an aborted 4-phase.
//     - Single requester always valid: back-to-back transfers, one per handshake round trip.
// CONFIGURATION
//   FULL_HANDSHAKE_TX_TIMEOUT_EN defined
//     - 8-bit wait counter, cleared on entering REQ_HI and counting each cycle in REQ_HI.
//     - If it reaches TIMEOUT_CYC-1 with ch_ack=0:
//         ch_req<=0, timeout_err pulses 1 cycle, go WAIT_LO; xfer_done still pulses on exit from WAIT_LO.
//   Not defined
//     - No counter; REQ_HI waits indefinitely; timeout_err is constant 0.
// TESTING
//   T1 reset
//     - Hold rst_n_t=0 for 40 ns.
//     - Required: ch_req=0, req_rdy=0, busy=0, xfer_done=0, xfer_id=0.
//   T2 single transfer
//     - req_val=4'b0100, data2=32'h0000_1234; ack rises 3 cycles after ch_req rises, falls 3 cycles later.
//     - Required:
//         req_rdy=4'b0100 for 1 cycle; ch_data=32'h1234; xfer_id=2;
//         ch_req falls 1 edge after ack rise; xfer_done 1 cycle after ack fall.
//   T3 round-robin
//     - req_val=4'b1111 held, auto-ack responder.
//     - Required: grant order 0,1,2,3,0; no grant while busy=1.
//   T4 wrap/fairness
//     - req_val=4'b1001 held, starting after the grant to requester 3.
//     - Required: grant order 0,3,0,3.
//   T5 ack stuck low (macro on, TIMEOUT_CYC=64)
//     - Required: timeout_err pulses once 64 cycles after the ch_req rise, ch_req=0, then xfer_done.
//     - Macro off: ch_req stays 1 for 200 cycles and timeout_err=0.
//   T6 reset during REQ_HI
//     - Required: ch_req=0 immediately; after release, requester 0 is granted first.

Source files
------------

// File: rtl/full_handshake_tx_arbiter_if.sv
// Requester and CDC-channel bundle for the shared transmit arbiter.
// master = arbiter side, slave = requesters plus channel side.
interface full_handshake_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_val;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_rdy;
  logic                      ch_req;
  logic [DATA_W-1:0]         ch_data;
  logic                      ch_ack;
  logic                      busy;
  logic                      xfer_done;
  logic [ID_W-1:0]           xfer_id;
  logic                      timeout_err;

  modport master (
    input  req_val, req_data, ch_ack,
    output req_rdy, ch_req, ch_data,
    output busy, xfer_done, xfer_id, timeout_err
  );

  modport slave (
    output req_val, req_data, ch_ack,
    input  req_rdy, ch_req, ch_data,
    input  busy, xfer_done, xfer_id, timeout_err
  );
endinterface

// File: rtl/full_handshake_tx_arbiter.sv
// Round-robin arbiter feeding one 4-phase req/ack CDC transmit channel.
// Define FULL_HANDSHAKE_TX_TIMEOUT_EN to abort a REQ_HI that never sees ack.
module full_handshake_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk_t,
  input  logic rst_n_t,
  full_handshake_tx_arbiter_if.master bus
);

  if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 ||
      TIMEOUT_CYC < 2 || TIMEOUT_CYC > 256) begin : g_bad_param
    $error("full_handshake_tx_arbiter: illegal parameters");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_HI  = 2'd1,
    WAIT_LO = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              ch_req_q, ch_req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic [ID_W-1:0]   win, idx;
  logic              found;
`ifdef FULL_HANDSHAKE_TX_TIMEOUT_EN
  logic [7:0]        cnt_q, cnt_d;
  logic              terr_q, terr_d;
`endif

  // Scan starts one past the last winner so every active requester is served in turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
      if (!found && bus.req_val[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    bus.req_rdy = '0;
    if (state_q == IDLE && found)
      bus.req_rdy = NUM_REQ'(1) << win;
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    id_d     = id_q;
    ch_req_d = ch_req_q;
    data_d   = data_q;
    done_d   = 1'b0;
`ifdef FULL_HANDSHAKE_TX_TIMEOUT_EN
    cnt_d    = cnt_q;
    terr_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          data_d   = bus.req_data[int'(win)*DATA_W +: DATA_W];
          ch_req_d = 1'b1;
          id_d     = win;
          rr_d     = win;
          state_d  = REQ_HI;
`ifdef FULL_HANDSHAKE_TX_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      REQ_HI: begin
`ifdef FULL_HANDSHAKE_TX_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (bus.ch_ack) begin
          ch_req_d = 1'b0;
          state_d  = WAIT_LO;
        end
`ifdef FULL_HANDSHAKE_TX_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          ch_req_d = 1'b0;
          terr_d   = 1'b1;
          state_d  = WAIT_LO;
        end
`endif
      end
      WAIT_LO: begin
        if (!bus.ch_ack) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_t or negedge rst_n_t) begin
    if (!rst_n_t) begin
      state_q  <= IDLE;
      rr_q     <= ID_W'(NUM_REQ - 1);
      id_q     <= '0;
      ch_req_q <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
`ifdef FULL_HANDSHAKE_TX_TIMEOUT_EN
      cnt_q    <= '0;
      terr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      ch_req_q <= ch_req_d;
      data_q   <= data_d;
      done_q   <= done_d;
`ifdef FULL_HANDSHAKE_TX_TIMEOUT_EN
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
`endif
    end
  end

  assign bus.ch_req    = ch_req_q;
  assign bus.ch_data   = data_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.xfer_done = done_q;
  assign bus.xfer_id   = id_q;
`ifdef FULL_HANDSHAKE_TX_TIMEOUT_EN
  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_full_handshake_tx_arbiter.sv
// Bench for full_handshake_tx_arbiter: transaction-level model
// compared every cycle, plus directed literal checks.
module tb_full_handshake_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int TO = 64;
`ifdef FULL_HANDSHAKE_TX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk_t = 1'b0;
  logic rst_n_t = 1'b0;
  logic auto_ack = 1'b0;
  logic ack_man = 1'b0;
  logic ack_auto = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  full_handshake_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) bus ();

  full_handshake_tx_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .ID_W(IW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_t  (clk_t),
    .rst_n_t(rst_n_t),
    .bus    (bus)
  );

  always #5 clk_t = ~clk_t;

  assign bus.ch_ack = auto_ack ? ack_auto : ack_man;

  // Channel responder: ack follows ch_req one cycle late.
  always @(posedge clk_t) begin
    #1;
    ack_auto = bus.ch_req;
  end

  always @(posedge clk_t) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          m_phase = 0;   // 0 idle, 1 awaiting ack high, 2 awaiting ack low
  int          m_ptr = NR - 1;
  logic        m_req = 1'b0;
  logic [31:0] m_data = '0;
  int          m_id = 0;
  logic        m_done = 1'b0;
  logic        m_terr = 1'b0;
  int          m_rise = 0;
  int          grants[$];

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 1; k <= NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  always @(posedge clk_t or negedge rst_n_t) begin
    if (!rst_n_t) begin
      m_phase <= 0;
      m_ptr   <= NR - 1;
      m_req   <= 1'b0;
      m_data  <= '0;
      m_id    <= 0;
      m_done  <= 1'b0;
      m_terr  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_terr <= 1'b0;
      if (m_phase == 0) begin
        if (pick(bus.req_val, m_ptr) >= 0) begin
          m_phase <= 1;
          m_req   <= 1'b1;
          m_id    <= pick(bus.req_val, m_ptr);
          m_ptr   <= pick(bus.req_val, m_ptr);
          m_data  <= bus.req_data[pick(bus.req_val, m_ptr)*DW +: DW];
          m_rise  <= cyc;
          grants.push_back(pick(bus.req_val, m_ptr));
        end
      end else if (m_phase == 1) begin
        if (bus.ch_ack) begin
          m_req   <= 1'b0;
          m_phase <= 2;
        end else if (TO_EN && (cyc - m_rise == TO)) begin
          m_req   <= 1'b0;
          m_terr  <= 1'b1;
          m_phase <= 2;
        end
      end else if (!bus.ch_ack) begin
        m_done  <= 1'b1;
        m_phase <= 0;
      end
    end
  end

  function automatic logic [NR-1:0] exp_rdy();
    int w;
    w = pick(bus.req_val, m_ptr);
    if (m_phase != 0 || w < 0) return '0;
    return NR'(1) << w;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_t) begin
    chk("req_rdy", 64'(bus.req_rdy), 64'(exp_rdy()));
    chk("ch_req", 64'(bus.ch_req), 64'(m_req));
    chk("ch_data", 64'(bus.ch_data), 64'(m_data));
    chk("busy", 64'(bus.busy), 64'(m_phase != 0));
    chk("xfer_done", 64'(bus.xfer_done), 64'(m_done));
    chk("xfer_id", 64'(bus.xfer_id), 64'(m_id));
    chk("timeout_err", 64'(bus.timeout_err), 64'(m_terr));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk_t);
    #1;
  endtask

  task automatic wait_grants(input int n);
    int b;
    b = 0;
    while (grants.size() < n && b < 200) begin
      step(1);
      b++;
    end
    chk("grant_count", 64'(grants.size()), 64'(n));
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((m_phase != 0 || bus.busy) && b < 100) begin
      step(1);
      b++;
    end
    chk("idle_reached", 64'(bus.busy), 64'd0);
  endtask

  task automatic chk_order(input string nm, input int e0, input int e1,
                           input int e2, input int e3, input int e4);
    int e[5];
    e = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < 5; i++)
      chk(nm, 64'(i < grants.size() ? grants[i] : -1), 64'(e[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, t_at, t_cnt, hi_cnt;
    bit d_seen;
    bus.req_val = '0;
    for (int i = 0; i < NR; i++)
      bus.req_data[i*DW +: DW] = 32'hA000_0000 + 32'(i);

    // T1 reset
    #20;
    chk("t1_ch_req", 64'(bus.ch_req), 64'd0);
    chk("t1_req_rdy", 64'(bus.req_rdy), 64'd0);
    chk("t1_busy", 64'(bus.busy), 64'd0);
    chk("t1_xfer_done", 64'(bus.xfer_done), 64'd0);
    chk("t1_xfer_id", 64'(bus.xfer_id), 64'd0);
    #20;
    rst_n_t = 1'b1;
    step(1);

    // T2 single transfer from requester 2
    bus.req_data[2*DW +: DW] = 32'h0000_1234;
    bus.req_val = 4'b0100;
    #3;
    chk("t2_req_rdy", 64'(bus.req_rdy), 64'h4);
    step(1);
    bus.req_val = '0;
    chk("t2_ch_req", 64'(bus.ch_req), 64'd1);
    chk("t2_ch_data", 64'(bus.ch_data), 64'h1234);
    chk("t2_xfer_id", 64'(bus.xfer_id), 64'd2);
    chk("t2_rdy_gone", 64'(bus.req_rdy), 64'd0);
    step(2);
    ack_man = 1'b1;
    chk("t2_req_held", 64'(bus.ch_req), 64'd1);
    step(1);
    chk("t2_req_fall", 64'(bus.ch_req), 64'd0);
    step(2);
    ack_man = 1'b0;
    chk("t2_no_done", 64'(bus.xfer_done), 64'd0);
    step(1);
    chk("t2_done", 64'(bus.xfer_done), 64'd1);
    chk("t2_idle", 64'(bus.busy), 64'd0);
    step(1);
    chk("t2_done_pulse", 64'(bus.xfer_done), 64'd0);

    // T3 round-robin from a fresh reset
    rst_n_t = 1'b0;
    step(1);
    rst_n_t = 1'b1;
    grants.delete();
    auto_ack = 1'b1;
    bus.req_val = 4'b1111;
    wait_grants(5);
    bus.req_val = '0;
    wait_idle();
    chk_order("t3_order", 0, 1, 2, 3, 0);

    // T4 wrap and fairness after a grant to requester 3
    grants.delete();
    bus.req_val = 4'b1000;
    wait_grants(1);
    bus.req_val = 4'b1001;
    wait_grants(5);
    bus.req_val = '0;
    wait_idle();
    chk_order("t4_order", 3, 0, 3, 0, 3);

    // T5 ack stuck low
    auto_ack = 1'b0;
    ack_man = 1'b0;
    bus.req_val = 4'b0001;
    step(1);
    bus.req_val = '0;
    c0 = cyc;
    t_at = -1;
    t_cnt = 0;
    hi_cnt = 0;
    d_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.ch_req) hi_cnt++;
      step(1);
      if (bus.timeout_err) begin
        t_cnt++;
        if (t_at < 0) t_at = cyc - c0;
      end
      if (bus.xfer_done) d_seen = 1'b1;
    end
`ifdef FULL_HANDSHAKE_TX_TIMEOUT_EN
    chk("t5_timeout_at", 64'(t_at), 64'd64);
    chk("t5_timeout_once", 64'(t_cnt), 64'd1);
    chk("t5_done_after", 64'(d_seen), 64'd1);
    chk("t5_req_low", 64'(bus.ch_req), 64'd0);
`else
    chk("t5_req_hi_cycles", 64'(hi_cnt), 64'd200);
    chk("t5_no_timeout", 64'(t_cnt), 64'd0);
    chk("t5_no_done", 64'(d_seen), 64'd0);
    ack_man = 1'b1;
    step(2);
    ack_man = 1'b0;
    step(2);
`endif
    wait_idle();

    // T6 reset during REQ_HI
    bus.req_val = 4'b0010;
    step(1);
    bus.req_val = '0;
    step(2);
    chk("t6_in_req_hi", 64'(bus.ch_req), 64'd1);
    #2;
    rst_n_t = 1'b0;
    #1;
    chk("t6_async_drop", 64'(bus.ch_req), 64'd0);
    chk("t6_busy_clr", 64'(bus.busy), 64'd0);
    bus.req_val = 4'b1111;
    step(1);
    rst_n_t = 1'b1;
    step(1);
    chk("t6_first_id", 64'(bus.xfer_id), 64'd0);
    chk("t6_first_req", 64'(bus.ch_req), 64'd1);
    bus.req_val = '0;
    auto_ack = 1'b1;
    wait_idle();
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
